rs_erasure_decode_ctrl: RTL and testbench

RS_ERASURE_DECODE_CTRL -- requirements
Module: rs_erasure_decode_ctrl

---
 rtl/rs_erasure_decode_ctrl.sv | 117 +++++++++++
 tb/tb_rs_erasure_decode_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rs_erasure_decode_ctrl.sv
// rs_erasure_decode_ctrl: sequences one RS codeword through syndrome, decode and optional erasure retry (macro RS_ERASURE_RETRY_EN)
module rs_erasure_decode_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [79:0]      req_codeword,
    input  logic [9:0]       req_due_info,
    output logic [79:0]      dp_codeword,
    output logic [9:0]       dp_due_info,
    output logic [15:0]      dp_syndrome,
    input  logic [15:0]      synd_in,
    input  logic [1:0]       dec_result,
    input  logic [63:0]      dec_data,
    input  logic [1:0]       era_result,
    input  logic [63:0]      era_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_result,
    output logic [63:0]      rsp_data,
    output logic             rsp_erasure,
    output logic [CNT_W-1:0] ce_count,
    output logic [CNT_W-1:0] due_count,
    input  logic             clr_cnt
);
`ifdef RS_ERASURE_RETRY_EN
    typedef enum logic [2:0] {IDLE, SYND, DEC, ERASE, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYND, DEC, RESP} state_t;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Result 11 is not a legal outcome and is treated as uncorrectable
    function automatic logic [1:0] final_res(input logic [1:0] r);
        return (r == 2'b11) ? 2'b10 : r;
    endfunction
    state_t state;
    assign req_ready = (state == IDLE);
`ifndef RS_ERASURE_RETRY_EN
    logic unused_era;
    assign unused_era  = ^{era_result, era_data};
    assign rsp_erasure = 1'b0;
`endif
    // Control FSM with registered datapath and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dp_codeword <= '0;
            dp_due_info <= '0;
            dp_syndrome <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_data    <= '0;
`ifdef RS_ERASURE_RETRY_EN
            rsp_erasure <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    dp_codeword <= req_codeword;
                    dp_due_info <= req_due_info;
                    state       <= SYND;
                end
                SYND: begin
                    dp_syndrome <= synd_in;
                    state       <= DEC;
                end
                DEC: begin
`ifdef RS_ERASURE_RETRY_EN
                    if (dec_result == 2'b10 && $countones(dp_due_info) == 2) begin
                        state <= ERASE;
                    end else begin
                        rsp_result  <= final_res(dec_result);
                        rsp_data    <= dec_data;
                        rsp_erasure <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
`else
                    rsp_result <= final_res(dec_result);
                    rsp_data   <= dec_data;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
`endif
                end
`ifdef RS_ERASURE_RETRY_EN
                ERASE: begin
                    rsp_result  <= final_res(era_result);
                    rsp_data    <= era_data;
                    rsp_erasure <= 1'b1;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
`endif
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Saturating event counters updated at the response handshake; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count  <= '0;
            due_count <= '0;
        end else if (clr_cnt) begin
            ce_count  <= '0;
            due_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_result == 2'b01 && ce_count != CNT_MAX) ce_count <= ce_count + CNT_W'(1);
            if (rsp_result == 2'b10 && due_count != CNT_MAX) due_count <= due_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rs_erasure_decode_ctrl.sv
// tb_rs_erasure_decode_ctrl: directed and randomized transactions checked against a transaction-level model
module tb_rs_erasure_decode_ctrl;
    localparam int CNT_W = 3;
    localparam int MAXC = (1 << CNT_W) - 1;
`ifdef RS_ERASURE_RETRY_EN
    localparam bit ERA_EN = 1'b1;
`else
    localparam bit ERA_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, rsp_ready = 1'b0, clr_cnt = 1'b0;
    logic [79:0] req_codeword = '0;
    logic [9:0] req_due_info = '0;
    logic [15:0] synd_in = '0;
    logic [1:0] dec_result = '0, era_result = '0;
    logic [63:0] dec_data = '0, era_data = '0;
    logic req_ready, rsp_valid, rsp_erasure;
    logic [79:0] dp_codeword;
    logic [9:0] dp_due_info;
    logic [15:0] dp_syndrome;
    logic [1:0] rsp_result;
    logic [63:0] rsp_data;
    logic [CNT_W-1:0] ce_count, due_count;
    int vectors = 0, miscompares = 0;
    int ce_m = 0, due_m = 0;

    rs_erasure_decode_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_codeword(req_codeword), .req_due_info(req_due_info),
        .dp_codeword(dp_codeword), .dp_due_info(dp_due_info), .dp_syndrome(dp_syndrome),
        .synd_in(synd_in), .dec_result(dec_result), .dec_data(dec_data),
        .era_result(era_result), .era_data(era_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_data(rsp_data),
        .rsp_erasure(rsp_erasure), .ce_count(ce_count), .due_count(due_count),
        .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response exchange; expectations derived from the stated rules
    task automatic txn(input logic [79:0] cw, input logic [9:0] due, input logic [15:0] syn,
                       input logic [1:0] dres, input logic [63:0] ddat,
                       input logic [1:0] eres, input logic [63:0] edat,
                       input int hold, input bit clr);
        bit era;
        int lat, cycles;
        logic [1:0] raw, xres;
        logic [63:0] xdat;
        era  = ERA_EN && dres == 2'b10 && $countones(due) == 2;
        raw  = era ? eres : dres;
        xres = (raw == 2'b11) ? 2'b10 : raw;
        xdat = era ? edat : ddat;
        lat  = era ? 4 : 3;
        check("req_ready_idle", 80'(req_ready), 80'(1));
        req_codeword = cw; req_due_info = due; synd_in = syn;
        dec_result = dres; dec_data = ddat; era_result = eres; era_data = edat;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_codeword = 80'(~cw); req_due_info = ~due;
        cycles = 1;
        while (!rsp_valid && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", 80'(cycles), 80'(lat));
        check("dp_codeword", dp_codeword, cw);
        check("dp_due_info", 80'(dp_due_info), 80'(due));
        check("dp_syndrome", 80'(dp_syndrome), 80'(syn));
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 80'(rsp_valid), 80'(1));
            check("req_ready_busy", 80'(req_ready), 80'(0));
            check("rsp_result", 80'(rsp_result), 80'(xres));
            check("rsp_data", 80'(rsp_data), 80'(xdat));
            check("rsp_erasure", 80'(rsp_erasure), 80'(era));
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1; clr_cnt = clr;
        @(negedge clk);
        rsp_ready = 1'b0; clr_cnt = 1'b0;
        if (clr) begin
            ce_m = 0; due_m = 0;
        end else begin
            if (xres == 2'b01 && ce_m < MAXC) ce_m++;
            if (xres == 2'b10 && due_m < MAXC) due_m++;
        end
        check("rsp_valid_done", 80'(rsp_valid), 80'(0));
        check("ce_count", 80'(ce_count), 80'(ce_m));
        check("due_count", 80'(due_count), 80'(due_m));
    endtask

    initial begin
        logic [9:0] d;
        int i, j;
        #2;
        check("rst_valid", 80'(rsp_valid), 80'(0));
        check("rst_dp_cw", dp_codeword, 80'(0));
        check("rst_ce", 80'(ce_count), 80'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 80'(req_ready), 80'(1));
        check("rst_result", 80'(rsp_result), 80'(0));
        check("rst_erasure", 80'(rsp_erasure), 80'(0));
        // clean codeword
        txn(80'h0123_4567_89AB_CDEF_1122, 10'd0, 16'h0000, 2'b00, 64'h0123_4567_89AB_CDEF, 2'b00, 64'd0, 0, 0);
        // single CE
        txn(80'hDEAD_BEEF_0000_1111_2222, 10'd0, 16'h1234, 2'b01, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 64'd0, 0, 0);
        // DUE with two erasures: erasure retry when enabled
        txn(80'h55AA_55AA_55AA_55AA_55AA, 10'b00_0000_0011, 16'hBEEF, 2'b10, 64'h1, 2'b01, 64'hFEED_FACE_CAFE_F00D, 1, 0);
        // DUE with three erasures, response held off for 5 cycles
        txn(80'h1111_2222_3333_4444_5555, 10'b00_0000_0111, 16'h00FF, 2'b10, 64'h2, 2'b01, 64'h3, 5, 0);
        // illegal 11 results
        txn(80'h9, 10'd0, 16'h1, 2'b11, 64'h4, 2'b00, 64'h5, 0, 0);
        txn(80'hA, 10'b10_0000_0001, 16'h2, 2'b10, 64'h6, 2'b11, 64'h7, 0, 0);
        // reset while in SYND discards the request
        req_codeword = 80'hFFFF_0000_FFFF_0000_FFFF; req_due_info = 10'h3FF;
        synd_in = 16'hABCD; dec_result = 2'b01;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        ce_m = 0; due_m = 0;
        check("mid_rst_valid", 80'(rsp_valid), 80'(0));
        check("mid_rst_dp_cw", dp_codeword, 80'(0));
        check("mid_rst_dp_due", 80'(dp_due_info), 80'(0));
        check("mid_rst_ce", 80'(ce_count), 80'(0));
        check("mid_rst_due", 80'(due_count), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_valid", 80'(rsp_valid), 80'(0));
            check("post_rst_ready", 80'(req_ready), 80'(1));
        end
        // saturate ce_count, then clear concurrent with a CE handshake
        for (int k = 0; k < MAXC + 2; k++)
            txn(80'(k), 10'd0, 16'(k), 2'b01, 64'(k * 3), 2'b00, 64'd0, 0, 0);
        check("ce_saturated", 80'(ce_count), 80'(MAXC));
        txn(80'h77, 10'd0, 16'h7, 2'b01, 64'h77, 2'b00, 64'd0, 0, 1);
        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: d = 10'($urandom);
                1: begin
                    i = $urandom_range(0, 9);
                    j = (i + 1 + $urandom_range(0, 8)) % 10;
                    d = (10'd1 << i) | (10'd1 << j);
                end
                default: d = 10'd0;
            endcase
            txn({$urandom, $urandom, 16'($urandom)}, d, 16'($urandom), 2'($urandom),
                {$urandom, $urandom}, 2'($urandom), {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
